// File: rtl/msrv32_integer_file.sv
// msrv32 integer register file: 32 x WIDTH registers, x0 hardwired to zero,
// two combinational read ports and one synchronous write port.
// Optional macro MSRV32_INTEGER_FILE_FORWARD_EN compiles in a same-cycle
// write-to-read bypass; the default build reads the pre-write array value.
module msrv32_integer_file #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [4:0]       rs_1_addr_in,
    input  logic [4:0]       rs_2_addr_in,
    input  logic [4:0]       rd_addr_in,
    input  logic             wr_en_in,
    input  logic [WIDTH-1:0] rd_in,
    output logic [WIDTH-1:0] rs_1_out,
    output logic [WIDTH-1:0] rs_2_out
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;

    // x0 is not stored; index 0 is handled by the read muxes
    logic [WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [WIDTH-1:0] regs_d [1:NUM_REGS-1];

    logic [WIDTH-1:0] rs_1_arr;
    logic [WIDTH-1:0] rs_2_arr;

    // Next-state: reset clears everything and wins over a write; writes to x0 drop
    always_comb begin
        regs_d = regs_q;
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en_in) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_addr_in == ADDR_W'(i)) begin
                    regs_d[i] = rd_in;
                end
            end
        end
    end

    // Register array update
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        regs_q <= regs_d;
    end

    // Array read muxes; index 0 falls through to zero
    always_comb begin
        rs_1_arr = '0;
        rs_2_arr = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_1_addr_in == ADDR_W'(i)) begin
                rs_1_arr = regs_q[i];
            end
            if (rs_2_addr_in == ADDR_W'(i)) begin
                rs_2_arr = regs_q[i];
            end
        end
    end

`ifdef MSRV32_INTEGER_FILE_FORWARD_EN
    logic fwd_ok;

    // Bypass the incoming write data to a port reading the register being written
    always_comb begin
        fwd_ok   = wr_en_in && !ms_riscv32_mp_rst_in && (rd_addr_in != '0);
        rs_1_out = (fwd_ok && (rd_addr_in == rs_1_addr_in)) ? rd_in : rs_1_arr;
        rs_2_out = (fwd_ok && (rd_addr_in == rs_2_addr_in)) ? rd_in : rs_2_arr;
    end
`else
    // No bypass: ports always show the current array contents
    always_comb begin
        rs_1_out = rs_1_arr;
        rs_2_out = rs_2_arr;
    end
`endif

endmodule
